pc_sequencer: RTL

Parametrised program-counter unit for the RISC-V core, replacing the bare PC adder plus 2:1 next-PC mux with a registered PC, an N-source priority redirect path, a valid/ready fetch handshake, and stall buffering. It sits at the head of the fetch stage. It drives the fetch address and the sequential PC+INC value, and receives redirects from branch, jump and trap logic downstream.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_redirect_arb.sv | 36 +++
 rtl/pc_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared state type and default parameter values for the program-counter sequencer.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } pc_state_t;

   localparam int          DEF_XLEN       = 32;
   localparam int          DEF_INC        = 4;
   localparam int          DEF_ALIGN_BITS = 2;
   localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority select over the redirect sources; index 0 wins.
// Emits the winning target with its low alignment bits cleared plus a misalign flag.
module pc_redirect_arb
   import pc_pkg::*;
#(
   parameter int XLEN       = DEF_XLEN,
   parameter int NUM_SRC    = 4,
   parameter int ALIGN_BITS = DEF_ALIGN_BITS
) (
   input  logic [NUM_SRC-1:0]      redirect_valid,
   input  logic [NUM_SRC*XLEN-1:0] redirect_target,
   output logic                    valid,
   output logic [XLEN-1:0]         target,
   output logic                    misalign
);

   localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

   logic [XLEN-1:0] raw;

   // Walk from the lowest priority upward so the lowest set index is written last.
   always_comb begin
      valid = 1'b0;
      raw   = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (redirect_valid[k]) begin
            valid = 1'b1;
            raw   = redirect_target[k*XLEN +: XLEN];
         end
      end
   end

   assign target   = raw & ALIGN_MASK;
   assign misalign = valid && (|(raw & ~ALIGN_MASK));

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC with priority redirect, fetch handshake and stall-time redirect buffering.
// Optional macro PC_FAULT_INJ_EN adds fault_en_i/fault_mask_i to XOR every PC load.
//
// state | meaning
// BOOT  | first cycle out of reset, PC at RESET_VEC, no fetch issued
// RUN   | PC valid for fetch, advances on handshake or redirect
// STALL | PC frozen, incoming redirects parked in the pending register
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              XLEN       = DEF_XLEN,
   parameter int              NUM_SRC    = 4,
   parameter int              INC        = DEF_INC,
   parameter int              ALIGN_BITS = DEF_ALIGN_BITS,
   parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall_i,
   input  logic [NUM_SRC-1:0]      redirect_valid_i,
   input  logic [NUM_SRC*XLEN-1:0] redirect_target_i,
   input  logic                    fetch_ready_i,
   output logic                    fetch_valid_o,
   output logic [XLEN-1:0]         pc_o,
   output logic [XLEN-1:0]         pc_plus_inc_o,
`ifdef PC_FAULT_INJ_EN
   input  logic                    fault_en_i,
   input  logic [XLEN-1:0]         fault_mask_i,
`endif
   output logic                    misalign_o
);

   pc_state_t       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, load_val, fault_xor;
   logic            load;
   logic            pend_vld_q, pend_vld_d, pend_mis_q, pend_mis_d;
   logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
   logic            mis_q, mis_d;
   logic            arb_valid, arb_misalign;
   logic [XLEN-1:0] arb_target;

   pc_redirect_arb #(
      .XLEN       (XLEN),
      .NUM_SRC    (NUM_SRC),
      .ALIGN_BITS (ALIGN_BITS)
   ) u_arb (
      .redirect_valid  (redirect_valid_i),
      .redirect_target (redirect_target_i),
      .valid           (arb_valid),
      .target          (arb_target),
      .misalign        (arb_misalign)
   );

`ifdef PC_FAULT_INJ_EN
   assign fault_xor = fault_en_i ? fault_mask_i : '0;
`else
   assign fault_xor = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= BOOT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT, RUN, STALL: state_d = stall_i ? STALL : RUN;
         default:          state_d = BOOT;
      endcase
   end

   always_comb begin
      fetch_valid_o = (state_q == RUN);
   end

   assign pc_o          = pc_q;
   assign pc_plus_inc_o = pc_q + XLEN'(INC);
   assign misalign_o    = mis_q;

   // Stall beats everything; a live redirect beats a parked one, which beats the increment.
   always_comb begin
      pend_vld_d = pend_vld_q;
      pend_tgt_d = pend_tgt_q;
      pend_mis_d = pend_mis_q;
      mis_d      = 1'b0;
      load       = 1'b0;
      load_val   = pc_q;
      if (stall_i) begin
         if (arb_valid) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = arb_target;
            pend_mis_d = arb_misalign;
         end
      end else if (arb_valid) begin
         load       = 1'b1;
         load_val   = arb_target;
         mis_d      = arb_misalign;
         pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
         load       = 1'b1;
         load_val   = pend_tgt_q;
         mis_d      = pend_mis_q;
         pend_vld_d = 1'b0;
      end else if (fetch_valid_o && fetch_ready_i) begin
         load       = 1'b1;
         load_val   = pc_plus_inc_o;
      end
      pc_d = load ? (load_val ^ fault_xor) : pc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_VEC;
         pend_vld_q <= 1'b0;
         pend_tgt_q <= '0;
         pend_mis_q <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pend_vld_q <= pend_vld_d;
         pend_tgt_q <= pend_tgt_d;
         pend_mis_q <= pend_mis_d;
         mis_q      <= mis_d;
      end
   end

endmodule
